// File: rtl/ecc_dmem_scrubber_pkg.sv
// Hamming-SECDED codeword constants, layout and helper functions for the dmem.
// Shared by the dmem encoder and the background scrubber.
package ecc_dmem_scrubber_pkg;

  localparam int unsigned DW    = 32;
  localparam int unsigned CW    = 39;
  localparam int unsigned SW    = 6;
  localparam int unsigned HMAX  = 38;
  localparam int unsigned CNT_W = 16;

  typedef logic [DW-1:0] dataword_t;
  typedef logic [CW-1:0] codeword_t;
  typedef logic [SW-1:0] syndrome_t;

  // Bits [38:1] hold Hamming positions 1..38, bit [0] is the overall parity.
  typedef struct packed {
    logic [HMAX:1] ham;
    logic          overall;
  } cw_layout_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_REQ,
    S_RD,
    S_CHK,
    S_WR,
    S_NEXT
  } state_t;

  function automatic logic is_parity_pos(input int unsigned pos);
    return (pos != 32'd0) && ((pos & (pos - 32'd1)) == 32'd0);
  endfunction

  // XOR of the indices of every set Hamming position.
  function automatic syndrome_t ecc_syndrome(input codeword_t cw);
    syndrome_t s;
    s = '0;
    for (int unsigned pos = 1; pos <= HMAX; pos++) begin
      if (cw[6'(pos)]) s = s ^ 6'(pos);
    end
    return s;
  endfunction

  function automatic dataword_t ecc_extract(input codeword_t cw);
    dataword_t   d;
    int unsigned k;
    d = '0;
    k = 0;
    for (int unsigned pos = 1; pos <= HMAX; pos++) begin
      if (!is_parity_pos(pos)) begin
        d[5'(k)] = cw[6'(pos)];
        k++;
      end
    end
    return d;
  endfunction

  // Data into non-power-of-two positions, then parity bits zero the syndrome.
  function automatic codeword_t ecc_encode(input dataword_t d);
    codeword_t   cw;
    syndrome_t   s;
    int unsigned k;
    cw = '0;
    k  = 0;
    for (int unsigned pos = 1; pos <= HMAX; pos++) begin
      if (!is_parity_pos(pos)) begin
        cw[6'(pos)] = d[5'(k)];
        k++;
      end
    end
    s = ecc_syndrome(cw);
    for (int unsigned j = 0; j < SW; j++) begin
      cw[6'(32'd1 << j)] = s[3'(j)];
    end
    cw[0] = ^cw[CW-1:1];
    return cw;
  endfunction

endpackage

// File: rtl/ecc_dmem_scrubber_secded_decode.sv
// Combinational SECDED decoder: classifies a codeword and produces its corrected form.
module ecc_dmem_scrubber_secded_decode
  import ecc_dmem_scrubber_pkg::*;
(
  input  codeword_t cw,
  output dataword_t data_c,
  output codeword_t cw_fix_c,
  output logic      single_c,
  output logic      dbl_c,
  output syndrome_t syndrome_c
);

  cw_layout_t cwl;
  syndrome_t  s;
  logic       p;
  codeword_t  fix;

  assign cwl = cw;

  // Odd overall parity is a single error unless the syndrome points past the codeword.
  always_comb begin
    s        = ecc_syndrome(cw);
    p        = (^cwl.ham) ^ cwl.overall;
    fix      = cw;
    single_c = 1'b0;
    dbl_c    = 1'b0;
    if (p) begin
      if (32'(s) <= HMAX) begin
        fix      = cw ^ (CW'(1) << s);
        single_c = 1'b1;
      end else begin
        dbl_c = 1'b1;
      end
    end else if (s != '0) begin
      dbl_c = 1'b1;
    end
  end

  assign cw_fix_c   = fix;
  assign data_c     = ecc_extract(fix);
  assign syndrome_c = s;

endmodule

// File: rtl/ecc_dmem_scrubber.sv
// Background SECDED scrubber for dmem: walks every word, writes back single-bit
// corrections and counts/flags double-bit errors, sharing the port via req/gnt.
module ecc_dmem_scrubber
  import ecc_dmem_scrubber_pkg::*;
#(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned AW       = 6,
  parameter int unsigned INTERVAL = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scrub_en,
  input  logic             loader_done_in,
  output logic             mem_req,
  input  logic             mem_gnt,
  output logic [AW-1:0]    mem_addr,
  output logic             mem_we,
  output logic [CW-1:0]    mem_wdata,
  input  logic [CW-1:0]    mem_rdata,
  output logic             busy,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt,
  output logic [AW-1:0]    last_err_addr,
  output logic             err_irq
);

  localparam int unsigned IW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [IW-1:0] WAIT_LAST = IW'((INTERVAL == 0) ? 0 : INTERVAL - 1);
  localparam logic [AW-1:0] PTR_LAST  = AW'(DEPTH - 1);

  state_t          state_q, state_d;
  logic [AW-1:0]   ptr_q;
  logic [IW-1:0]   wait_q;
  logic            stop_q;
  codeword_t       rd_q;

  logic            wait_done;
  logic            wait_clr, wait_inc, ptr_inc, cap_rd, cap_fix;
  logic            corr_inc, uncorr_inc, err_log;

  dataword_t       dec_data;
  codeword_t       dec_fix;
  logic            dec_single, dec_dbl;
  syndrome_t       dec_syn;
  logic            dec_unused;

  ecc_dmem_scrubber_secded_decode u_dec (
    .cw         (rd_q),
    .data_c     (dec_data),
    .cw_fix_c   (dec_fix),
    .single_c   (dec_single),
    .dbl_c      (dec_dbl),
    .syndrome_c (dec_syn)
  );

  assign dec_unused = ^{dec_data, dec_syn};
  assign wait_done  = (INTERVAL == 0) || (wait_q == WAIT_LAST);
  assign mem_addr   = ptr_q;

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_d    = state_q;
    wait_clr   = 1'b0;
    wait_inc   = 1'b0;
    ptr_inc    = 1'b0;
    cap_rd     = 1'b0;
    cap_fix    = 1'b0;
    corr_inc   = 1'b0;
    uncorr_inc = 1'b0;
    err_log    = 1'b0;
    case (state_q)
      S_IDLE: begin
        wait_clr = 1'b1;
        if (scrub_en && loader_done_in) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!scrub_en) begin
          state_d  = S_IDLE;
          wait_clr = 1'b1;
        end else if (wait_done) begin
          state_d  = S_REQ;
          wait_clr = 1'b1;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_REQ: begin
        if (mem_gnt) state_d = S_RD;
      end
      S_RD: begin
        cap_rd  = 1'b1;
        state_d = S_CHK;
      end
      S_CHK: begin
        if (dec_single) begin
          cap_fix = 1'b1;
          err_log = 1'b1;
          state_d = S_WR;
        end else if (dec_dbl) begin
          uncorr_inc = 1'b1;
          err_log    = 1'b1;
          state_d    = S_NEXT;
        end else begin
          state_d = S_NEXT;
        end
      end
      // A lost grant means the CPU may have written this word; re-read it.
      S_WR: begin
        if (mem_gnt) begin
          corr_inc = 1'b1;
          state_d  = S_NEXT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_NEXT: begin
        ptr_inc = 1'b1;
        if (stop_q || !scrub_en) state_d = S_IDLE;
        else if (INTERVAL == 0)  state_d = S_REQ;
        else                     state_d = S_WAIT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      wait_q        <= '0;
      stop_q        <= 1'b0;
      rd_q          <= '0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_wdata     <= '0;
      busy          <= 1'b0;
      corr_cnt      <= '0;
      uncorr_cnt    <= '0;
      last_err_addr <= '0;
      err_irq       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (wait_clr)      wait_q <= '0;
      else if (wait_inc) wait_q <= wait_q + IW'(1);
      if (ptr_inc) ptr_q <= (ptr_q == PTR_LAST) ? '0 : ptr_q + AW'(1);
      // Remember a mid-word disable so the word finishes before going idle.
      if (state_q == S_IDLE || state_q == S_WAIT) stop_q <= 1'b0;
      else if (!scrub_en)                          stop_q <= 1'b1;
      if (cap_rd)  rd_q      <= mem_rdata;
      if (cap_fix) mem_wdata <= dec_fix;
      mem_req <= (state_d == S_REQ) || (state_d == S_WR);
      mem_we  <= (state_d == S_WR);
      busy    <= !((state_d == S_IDLE) || (state_d == S_WAIT));
      if (corr_inc && (corr_cnt != '1))     corr_cnt   <= corr_cnt + CNT_W'(1);
      if (uncorr_inc && (uncorr_cnt != '1)) uncorr_cnt <= uncorr_cnt + CNT_W'(1);
      if (err_log) last_err_addr <= ptr_q;
      err_irq <= uncorr_inc;
    end
  end

endmodule

// File: tb/tb_ecc_dmem_scrubber.sv
// Directed bench for ecc_dmem_scrubber: table of single-sweep error scenarios
// plus hand sequences for loader gating, word period and reset during write-back.
module tb_ecc_dmem_scrubber;

  localparam int unsigned DEPTH    = 64;
  localparam int unsigned AW       = 6;
  localparam int unsigned INTERVAL = 3;

  logic        clk;
  logic        rst;
  logic        scrub_en;
  logic        loader_done_in;
  logic        mem_req;
  logic        mem_gnt;
  logic [5:0]  mem_addr;
  logic        mem_we;
  logic [38:0] mem_wdata;
  logic [38:0] mem_rdata;
  logic        busy;
  logic [15:0] corr_cnt;
  logic [15:0] uncorr_cnt;
  logic [5:0]  last_err_addr;
  logic        err_irq;

  ecc_dmem_scrubber #(.DEPTH(DEPTH), .AW(AW), .INTERVAL(INTERVAL)) dut (
    .clk            (clk),
    .rst            (rst),
    .scrub_en       (scrub_en),
    .loader_done_in (loader_done_in),
    .mem_req        (mem_req),
    .mem_gnt        (mem_gnt),
    .mem_addr       (mem_addr),
    .mem_we         (mem_we),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .busy           (busy),
    .corr_cnt       (corr_cnt),
    .uncorr_cnt     (uncorr_cnt),
    .last_err_addr  (last_err_addr),
    .err_irq        (err_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dmem model: one-cycle read latency, writes on granted strobe.
  logic [38:0] mem      [DEPTH];
  logic [38:0] init_mem [DEPTH];
  logic        load;

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_mem[i];
    end else if (mem_req && mem_gnt) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  function automatic logic [38:0] enc(input logic [31:0] d);
    logic [38:0] c;
    logic        p;
    int          k;
    c = '0;
    k = 0;
    for (int pos = 1; pos <= 38; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[6'(pos)] = d[5'(k)];
        k++;
      end
    end
    for (int j = 0; j < 6; j++) begin
      p = 1'b0;
      for (int pos = 1; pos <= 38; pos++) if (pos[j]) p = p ^ c[6'(pos)];
      c[6'(1 << j)] = p;
    end
    c[0] = ^c[38:1];
    return c;
  endfunction

  typedef struct {
    logic [5:0]  idx;
    logic [38:0] flip;
    int          drop;
    int          writes;
    int          reads;
    logic [15:0] corr;
    logic [15:0] uncorr;
    int          irqs;
    logic [5:0]  last_err;
    logic [38:0] exp_xor;
  } vec_t;

  vec_t vecs [8];

  int          checks;
  int          failures;
  int          n_writes, n_reads, irq_pulses, irq_wide, ever_req, drop_left;
  logic        prev_irq, dropping;
  logic [5:0]  watch, last_waddr;
  logic [38:0] last_wdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: sample outputs at negedge, then drive grant for the next edge.
  task automatic step();
    @(negedge clk);
    if (err_irq) begin
      if (prev_irq) irq_wide++;
      else          irq_pulses++;
    end
    prev_irq = err_irq;
    if (mem_req) ever_req++;
    if (drop_left > 0 && (dropping || mem_we)) begin
      mem_gnt  = 1'b0;
      dropping = 1'b1;
      drop_left--;
    end else begin
      mem_gnt = 1'b1;
    end
    if (mem_req && mem_gnt) begin
      if (mem_we) begin
        n_writes++;
        last_waddr = mem_addr;
        last_wdata = mem_wdata;
      end else if (mem_addr == watch) begin
        n_reads++;
      end
    end
  endtask

  task automatic start_fresh(input logic [5:0] fidx, input logic [38:0] flip);
    rst            = 1'b0;
    scrub_en       = 1'b0;
    loader_done_in = 1'b0;
    mem_gnt        = 1'b1;
    drop_left      = 0;
    dropping       = 1'b0;
    for (int i = 0; i < DEPTH; i++) init_mem[i] = enc(32'(i) * 32'd13);
    init_mem[fidx] = init_mem[fidx] ^ flip;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    n_writes   = 0;
    n_reads    = 0;
    irq_pulses = 0;
    irq_wide   = 0;
    ever_req   = 0;
    prev_irq   = 1'b0;
    last_waddr = '0;
    last_wdata = '0;
    rst        = 1'b1;
  endtask

  task automatic run_vec(input int vi, input vec_t v);
    int   k;
    logic seen_last;
    start_fresh(v.idx, v.flip);
    watch          = v.idx;
    drop_left      = v.drop;
    scrub_en       = 1'b1;
    loader_done_in = 1'b1;
    seen_last      = 1'b0;
    k              = 0;
    while (!seen_last && k < 2000) begin
      step();
      if (mem_req && mem_gnt && !mem_we && mem_addr == 6'd63) seen_last = 1'b1;
      k++;
    end
    check($sformatf("v%0d_sweep_reached_63", vi), 64'(seen_last), 64'd1);
    scrub_en = 1'b0;
    k = 0;
    do begin
      step();
      k++;
    end while (busy && k < 40);
    check($sformatf("v%0d_went_idle", vi), 64'(busy), 64'd0);
    ever_req = 0;
    repeat (6) step();
    check($sformatf("v%0d_no_req_after_stop", vi), 64'(ever_req), 64'd0);
    check($sformatf("v%0d_writes", vi), 64'(n_writes), 64'(v.writes));
    if (v.writes > 0) begin
      check($sformatf("v%0d_write_addr", vi), 64'(last_waddr), 64'(v.idx));
      check($sformatf("v%0d_write_data", vi), 64'(last_wdata), 64'(enc(32'(v.idx) * 32'd13)));
    end
    check($sformatf("v%0d_reads_of_idx", vi), 64'(n_reads), 64'(v.reads));
    check($sformatf("v%0d_corr_cnt", vi), 64'(corr_cnt), 64'(v.corr));
    check($sformatf("v%0d_uncorr_cnt", vi), 64'(uncorr_cnt), 64'(v.uncorr));
    check($sformatf("v%0d_irq_pulses", vi), 64'(irq_pulses), 64'(v.irqs));
    check($sformatf("v%0d_irq_width", vi), 64'(irq_wide), 64'd0);
    check($sformatf("v%0d_last_err_addr", vi), 64'(last_err_addr), 64'(v.last_err));
    check($sformatf("v%0d_mem_word", vi), 64'(mem[v.idx]),
          64'(enc(32'(v.idx) * 32'd13) ^ v.exp_xor));
    check($sformatf("v%0d_ptr_wrapped", vi), 64'(mem_addr), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    checks   = 0;
    failures = 0;
    load     = 1'b0;
    watch    = '0;
    //            idx    flip              drop wr rd corr   uncorr irq last   exp_xor
    vecs[0] = '{6'd1,  39'h0,            0,   0, 1, 16'd0, 16'd0, 0, 6'd0,  39'h0};
    vecs[1] = '{6'd1,  39'h8,            0,   1, 1, 16'd1, 16'd0, 0, 6'd1,  39'h0};
    vecs[2] = '{6'd1,  39'h60,           0,   0, 1, 16'd0, 16'd1, 1, 6'd1,  39'h60};
    vecs[3] = '{6'd1,  39'h8,            3,   1, 2, 16'd1, 16'd0, 0, 6'd1,  39'h0};
    vecs[4] = '{6'd1,  39'h1,            0,   1, 1, 16'd1, 16'd0, 0, 6'd1,  39'h0};
    vecs[5] = '{6'd63, 39'h40_0000_0000, 0,   1, 1, 16'd1, 16'd0, 0, 6'd63, 39'h0};
    vecs[6] = '{6'd5,  39'h01_0000_0180, 0,   0, 1, 16'd0, 16'd1, 1, 6'd5,  39'h01_0000_0180};
    vecs[7] = '{6'd62, 39'h6,            0,   0, 1, 16'd0, 16'd1, 1, 6'd62, 39'h6};

    // Reset state.
    start_fresh(6'd0, 39'h0);
    check("reset_ctrl", 64'({mem_req, mem_we, busy, err_irq}), 64'd0);
    check("reset_addr", 64'(mem_addr), 64'd0);
    check("reset_last_err", 64'(last_err_addr), 64'd0);
    check("reset_counters", 64'({corr_cnt, uncorr_cnt}), 64'd0);
    check("reset_wdata", 64'(mem_wdata), 64'd0);

    // No scrubbing until the loader is done; then first REQ after INTERVAL wait cycles.
    scrub_en = 1'b1;
    repeat (40) step();
    check("no_req_before_loader_done", 64'(ever_req), 64'd0);
    check("idle_before_loader_done", 64'(busy), 64'd0);
    loader_done_in = 1'b1;
    k = 0;
    do begin
      step();
      k++;
    end while (!mem_req && k < 50);
    check("first_req_latency", 64'(k), 64'(INTERVAL + 1));
    check("first_req_addr", 64'(mem_addr), 64'd0);
    k = 0;
    do begin
      step();
      k++;
    end while (!(mem_req && mem_addr == 6'd1) && k < 50);
    check("clean_word_period", 64'(k), 64'(INTERVAL + 4));

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Reset while a corrected write is pending but not yet granted.
    start_fresh(6'd1, 39'h8);
    scrub_en       = 1'b1;
    loader_done_in = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!mem_we && k < 200);
    check("wr_reached", 64'(mem_we), 64'd1);
    check("wr_addr", 64'(mem_addr), 64'd1);
    check("wr_data_original_cw", 64'(mem_wdata), 64'h00_0000_00CC);
    mem_gnt = 1'b0;
    rst     = 1'b0;
    #1;
    check("rst_in_wr_req", 64'(mem_req), 64'd0);
    check("rst_in_wr_we", 64'(mem_we), 64'd0);
    check("rst_in_wr_busy", 64'(busy), 64'd0);
    check("rst_in_wr_counters", 64'({corr_cnt, uncorr_cnt}), 64'd0);
    repeat (3) @(negedge clk);
    check("rst_in_wr_mem_untouched", 64'(mem[1]), 64'h00_0000_00C4);
    scrub_en = 1'b0;
    mem_gnt  = 1'b1;
    rst      = 1'b1;
    repeat (3) @(negedge clk);
    check("after_rst_no_req", 64'({mem_req, mem_we}), 64'd0);
    check("after_rst_corr_cnt", 64'(corr_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
